i2s_tx_ctrl: RTL and testbench

I2S_TX_CTRL -- requirements
Module: i2s_tx_ctrl

---
 rtl/i2s_tx_ctrl.sv | 163 ++++++++++++++++
 tb/tb_i2s_tx_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_ctrl.sv
// I2S transmitter: serializes {left, right} sample pairs MSB-first with the
// standard one-bit delay after lrck, behind a single-entry holding register.
module i2s_tx_ctrl #(
    parameter int unsigned DIV   = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] sample_l,
    input  logic [WIDTH-1:0] sample_r,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             bck,
    output logic             lrck,
    output logic             sdata,
    output logic             underrun,
    output logic [7:0]       underrun_cnt
);

    localparam int unsigned FW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(FW);
    localparam logic [7:0]    PRESC_MAX = 8'(DIV - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(FW - 1);
    localparam logic [CW-1:0] CNT_RIGHT = CW'(WIDTH);

    typedef enum logic {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [7:0]       presc_q, presc_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             bck_q, bck_d;
    logic             lrck_q, lrck_d;
    logic             sdata_q, sdata_d;
    logic             underrun_q, underrun_d;
    logic [7:0]       ur_cnt_q, ur_cnt_d;
    logic [FW-1:0]    frame_q, frame_d;
    logic [WIDTH-1:0] hold_l_q, hold_l_d;
    logic [WIDTH-1:0] hold_r_q, hold_r_d;
    logic             hold_full_q, hold_full_d;
    logic             frame_start;
    logic             handshake;
    logic [CW-1:0]    cnt_inc;

    assign handshake = sample_valid & ~hold_full_q;
    assign cnt_inc   = bit_cnt_q + CW'(1);

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        bit_cnt_d   = bit_cnt_q;
        bck_d       = bck_q;
        lrck_d      = lrck_q;
        sdata_d     = sdata_q;
        underrun_d  = 1'b0;
        ur_cnt_d    = ur_cnt_q;
        frame_d     = frame_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        hold_full_d = hold_full_q;
        frame_start = 1'b0;

        unique case (state_q)
            StIdle: begin
                presc_d   = '0;
                bit_cnt_d = '0;
                bck_d     = 1'b0;
                lrck_d    = 1'b0;
                sdata_d   = 1'b0;
                if (enable) begin
                    state_d     = StRun;
                    frame_start = 1'b1;
                end
            end
            StRun: begin
                if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    bck_d   = ~bck_q;
                    if (bck_q) begin
                        // bck fall: advance one bit; the frame shifts out of its MSB
                        if (bit_cnt_q == CNT_LAST) begin
                            bit_cnt_d = '0;
                            lrck_d    = 1'b0;
                            if (enable) begin
                                sdata_d     = frame_q[FW-1];
                                frame_start = 1'b1;
                            end else begin
                                state_d = StIdle;
                                sdata_d = 1'b0;
                            end
                        end else begin
                            bit_cnt_d = cnt_inc;
                            lrck_d    = (cnt_inc >= CNT_RIGHT);
                            sdata_d   = frame_q[FW-1];
                            frame_d   = {frame_q[FW-2:0], 1'b0};
                        end
                    end
                end else begin
                    presc_d = presc_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Transfer uses the holding register's old content; a same-edge handshake refills it.
        if (frame_start) begin
            if (hold_full_q) begin
                frame_d     = {hold_l_q, hold_r_q};
                hold_full_d = 1'b0;
            end else begin
                frame_d    = '0;
                underrun_d = 1'b1;
                if (ur_cnt_q != 8'hFF) begin
                    ur_cnt_d = ur_cnt_q + 8'd1;
                end
            end
        end

        if (handshake) begin
            hold_l_d    = sample_l;
            hold_r_d    = sample_r;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            presc_q     <= '0;
            bit_cnt_q   <= '0;
            bck_q       <= 1'b0;
            lrck_q      <= 1'b0;
            sdata_q     <= 1'b0;
            underrun_q  <= 1'b0;
            ur_cnt_q    <= '0;
            frame_q     <= '0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            bit_cnt_q   <= bit_cnt_d;
            bck_q       <= bck_d;
            lrck_q      <= lrck_d;
            sdata_q     <= sdata_d;
            underrun_q  <= underrun_d;
            ur_cnt_q    <= ur_cnt_d;
            frame_q     <= frame_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            hold_full_q <= hold_full_d;
        end
    end

    assign sample_ready = ~hold_full_q;
    assign bck          = bck_q;
    assign lrck         = lrck_q;
    assign sdata        = sdata_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = ur_cnt_q;

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// Directed bench for i2s_tx_ctrl: streaming, underrun, saturation, same-edge
// handshake, graceful stop and mid-frame reset.
`timescale 1ns / 1ps
module tb_i2s_tx_ctrl;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] sample_l;
    logic [15:0] sample_r;
    logic        sample_valid;
    logic        sample_ready;
    logic        bck;
    logic        lrck;
    logic        sdata;
    logic        underrun;
    logic [7:0]  underrun_cnt;

    logic        enable_s;
    logic [7:0]  sample_l_s;
    logic [7:0]  sample_r_s;
    logic        sample_valid_s;
    logic        sample_ready_s;
    logic        bck_s;
    logic        lrck_s;
    logic        sdata_s;
    logic        underrun_s;
    logic [7:0]  underrun_cnt_s;

    int checks = 0;
    int errors = 0;

    i2s_tx_ctrl #(.DIV(4), .WIDTH(16)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .bck          (bck),
        .lrck         (lrck),
        .sdata        (sdata),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    // Small configuration so 300 starved frames stay cheap: 32 clk per frame.
    i2s_tx_ctrl #(.DIV(1), .WIDTH(8)) u_sat (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable_s),
        .sample_l     (sample_l_s),
        .sample_r     (sample_r_s),
        .sample_valid (sample_valid_s),
        .sample_ready (sample_ready_s),
        .bck          (bck_s),
        .lrck         (lrck_s),
        .sdata        (sdata_s),
        .underrun     (underrun_s),
        .underrun_cnt (underrun_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered just after a frame-start edge; returns at the last cycle of that frame.
    task automatic run_frame(input logic [31:0] exp_frame, input logic exp_b0,
                             input logic exp_ur, input logic do_load,
                             input logic [15:0] nl, input logic [15:0] nr, input logic stop);
        int   k;
        logic exp_sd;
        check("underrun_at_start", underrun, exp_ur);
        for (int c = 0; c < 256; c++) begin
            if (c > 0) tick();
            if (c == 0 && do_load) begin
                sample_l     = nl;
                sample_r     = nr;
                sample_valid = 1'b1;
            end
            if (c == 1) begin
                sample_valid = 1'b0;
                check("underrun_one_clk", underrun, 1'b0);
            end
            if (stop && c == 42) enable = 1'b0;
            k = c / 8;
            if (c % 8 == 2) begin
                exp_sd = (k == 0) ? exp_b0 : exp_frame[32-k];
                check($sformatf("bck_low_b%0d", k), bck, 1'b0);
                check($sformatf("lrck_b%0d", k), lrck, (k >= 16));
                check($sformatf("sdata_b%0d", k), sdata, exp_sd);
            end
            if (c % 8 == 6) check($sformatf("bck_high_b%0d", k), bck, 1'b1);
        end
    endtask

    initial begin
        int   pulses;
        int   sat_pulses;
        logic [31:0] d_frame;

        reset          = 1'b1;
        enable         = 1'b0;
        sample_l       = '0;
        sample_r       = '0;
        sample_valid   = 1'b0;
        enable_s       = 1'b0;
        sample_l_s     = '0;
        sample_r_s     = '0;
        sample_valid_s = 1'b0;
        #3 reset = 1'b0;
        #2;
        check("rst_bck", bck, 1'b0);
        check("rst_lrck", lrck, 1'b0);
        check("rst_sdata", sdata, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_underrun_cnt", underrun_cnt, 8'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("ready_after_reset", sample_ready, 1'b1);

        // Preload A while idle
        sample_l     = 16'hA5C3;
        sample_r     = 16'h0F01;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check("ready_drops_after_load", sample_ready, 1'b0);
        check("idle_bck", bck, 1'b0);

        // Frame 0: A, first frame after idle so bit 0 is 0; load B during it
        enable = 1'b1;
        tick();
        check("ready_after_transfer", sample_ready, 1'b1);
        run_frame({16'hA5C3, 16'h0F01}, 1'b0, 1'b0, 1'b1, 16'h8001, 16'h7FFF, 1'b0);

        // Frame 1: B, bit 0 carries A's R[0]=1
        tick();
        check("ready_frame1", sample_ready, 1'b1);
        run_frame({16'h8001, 16'h7FFF}, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);

        // Frame 2: handshake on the frame-start edge with holding register empty
        sample_l     = 16'h1234;
        sample_r     = 16'hFEDC;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check("same_edge_ready", sample_ready, 1'b0);
        check("same_edge_cnt", underrun_cnt, 8'd1);
        run_frame(32'h0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
        check("held_pair_kept", sample_ready, 1'b0);

        // Frame 3: held pair C serialized; load D; drop enable at bit 5
        tick();
        check("ready_frame3", sample_ready, 1'b1);
        check("cnt_frame3", underrun_cnt, 8'd1);
        run_frame({16'h1234, 16'hFEDC}, 1'b0, 1'b0, 1'b1, 16'hC3A5, 16'h5A3C, 1'b1);
        tick();
        check("stop_bck", bck, 1'b0);
        check("stop_lrck", lrck, 1'b0);
        check("stop_sdata", sdata, 1'b0);
        check("stop_underrun", underrun, 1'b0);
        check("stop_cnt", underrun_cnt, 8'd1);
        check("stop_hold_kept", sample_ready, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        check("idle_stays_bck", bck, 1'b0);
        check("idle_stays_underrun", underrun, 1'b0);

        // Reset mid-frame at bit 20 of frame D
        d_frame = {16'hC3A5, 16'h5A3C};
        enable = 1'b1;
        tick();
        for (int i = 0; i < 166; i++) tick();
        check("pre_reset_bck", bck, 1'b1);
        check("pre_reset_lrck", lrck, 1'b1);
        check("pre_reset_sdata", sdata, d_frame[12]);
        reset = 1'b0;
        #1;
        check("async_bck", bck, 1'b0);
        check("async_lrck", lrck, 1'b0);
        check("async_sdata", sdata, 1'b0);
        check("async_cnt", underrun_cnt, 8'd0);
        enable = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("ready_after_midreset", sample_ready, 1'b1);
        check("idle_after_midreset", bck, 1'b0);

        // Underrun from idle with empty holding register
        enable = 1'b1;
        tick();
        check("underrun_cnt_1", underrun_cnt, 8'd1);
        run_frame(32'h0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
        enable = 1'b0;
        tick();
        check("underrun_stop_pulse", underrun, 1'b0);
        check("underrun_stop_cnt", underrun_cnt, 8'd1);

        // Saturation: 300 starved frames
        pulses     = 0;
        sat_pulses = 0;
        enable_s   = 1'b1;
        for (int i = 0; i < 9600; i++) begin
            tick();
            if (underrun_s === 1'b1) begin
                pulses++;
                if (underrun_cnt_s === 8'd255) sat_pulses++;
            end
        end
        check("sat_pulses", pulses, 300);
        check("sat_pulses_at_255", sat_pulses, 46);
        check("sat_cnt", underrun_cnt_s, 8'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
